// File: rtl/alu_flopr_mux2_if.sv
// Bundles the ALU, register and mux data signals of alu_flopr_mux2.
// Optional alu_ovf is present only when ALU_OVERFLOW_EN is defined.
interface alu_flopr_mux2_if #(
    parameter int WIDTH = 32
);
    // No handshake: every signal is a plain level, and a consumer samples it whenever it needs it.
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic             alu_cout;
    logic             alu_zero;
`ifdef ALU_OVERFLOW_EN
    logic             alu_ovf;
`endif
    logic             reg_en;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] mux_d0;
    logic [WIDTH-1:0] mux_d1;
    logic             mux_s;
    logic [WIDTH-1:0] mux_y;

    modport master (
        output alu_a, alu_b, alu_ctrl, reg_en, reg_d, mux_d0, mux_d1, mux_s,
        input  alu_result, alu_cout, alu_zero, reg_q, mux_y
`ifdef ALU_OVERFLOW_EN
        , alu_ovf
`endif
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl, reg_en, reg_d, mux_d0, mux_d1, mux_s,
        output alu_result, alu_cout, alu_zero, reg_q, mux_y
`ifdef ALU_OVERFLOW_EN
        , alu_ovf
`endif
    );
endinterface

// File: rtl/alu_flopr_mux2.sv
// 32-bit ALU, enabled resettable register and 2:1 mux sharing one interface.
// Define ALU_OVERFLOW_EN to add alu_ovf and make SLT a true signed compare.
module alu_flopr_mux2 #(
    parameter int             WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic              clk,
    input logic              reset,
    alu_flopr_mux2_if.slave  bus
);
    logic [31:0] w_bb;
    logic [32:0] w_sum33;
    logic [31:0] w_sum;
    logic        w_slt;
    logic [31:0] w_result;
    logic [WIDTH-1:0] r_q;

    // ctrl[2] turns the adder into a subtractor via ~b plus carry-in.
    assign w_bb    = bus.alu_ctrl[2] ? ~bus.alu_b : bus.alu_b;
    assign w_sum33 = {1'b0, bus.alu_a} + {1'b0, w_bb} + {32'b0, bus.alu_ctrl[2]};
    assign w_sum   = w_sum33[31:0];

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;
    assign w_ovf       = (bus.alu_a[31] == w_bb[31]) & (w_sum[31] != bus.alu_a[31]);
    assign bus.alu_ovf = w_ovf;
    // Only the SLT code gets the overflow fix; code 011 stays the raw sign of A+B.
    assign w_slt       = bus.alu_ctrl[2] ? (w_sum[31] ^ w_ovf) : w_sum[31];
`else
    assign w_slt       = w_sum[31];
`endif

    always_comb begin
        w_result = '0;
        case (bus.alu_ctrl[1:0])
            2'b00:   w_result = bus.alu_a & w_bb;
            2'b01:   w_result = bus.alu_a | w_bb;
            2'b10:   w_result = w_sum;
            default: w_result = {31'b0, w_slt};
        endcase
    end

    assign bus.alu_result = w_result;
    assign bus.alu_cout   = w_sum33[32];
    assign bus.alu_zero   = (w_result == 32'd0);

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= RESET_VALUE;
        else if (bus.reg_en)
            r_q <= bus.reg_d;
    end

    assign bus.reg_q = r_q;
    assign bus.mux_y = bus.mux_s ? bus.mux_d1 : bus.mux_d0;
endmodule

// File: tb/tb_alu_flopr_mux2.sv
// Directed bench for alu_flopr_mux2: ALU vector table, register sequences, mux checks.
module tb_alu_flopr_mux2;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    alu_flopr_mux2_if #(.WIDTH(WIDTH)) bus ();

    alu_flopr_mux2 #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        logic        zero;
        logic        ovf;
    } alu_vec_t;

    alu_vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset       = 1'b1;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_ctrl = '0;
        bus.reg_en  = 1'b0;
        bus.reg_d   = '0;
        bus.mux_d0  = '0;
        bus.mux_d1  = '0;
        bus.mux_s   = 1'b0;

        //            ctrl     a             b             res           cout  zero  ovf
        vecs[0]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 32'h0000_0003, 32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'b111, 32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b110, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
`ifdef ALU_OVERFLOW_EN
        vecs[12] = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
`else
        vecs[12] = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
`endif
        vecs[13] = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};

        // Register: reset, load, hold.
        @(negedge clk);
        tick();
        check("reg_after_reset", 64'(bus.reg_q), 64'h0);
        @(negedge clk);
        reset      = 1'b0;
        bus.reg_en = 1'b1;
        bus.reg_d  = 32'h0000_1234;
        #1;
        check("reg_no_load_before_edge", 64'(bus.reg_q), 64'h0);
        tick();
        check("reg_load", 64'(bus.reg_q), 64'h1234);
        @(negedge clk);
        bus.reg_en = 1'b0;
        bus.reg_d  = 32'h0000_5678;
        tick();
        check("reg_hold", 64'(bus.reg_q), 64'h1234);
        tick();
        check("reg_hold_2", 64'(bus.reg_q), 64'h1234);

        // Reset beats enable on the same edge.
        @(negedge clk);
        reset      = 1'b1;
        bus.reg_en = 1'b1;
        bus.reg_d  = 32'h0000_ABCD;
        tick();
        check("reg_reset_priority", 64'(bus.reg_q), 64'h0);

        // Mid-operation reset: no effect until the edge.
        @(negedge clk);
        reset      = 1'b0;
        bus.reg_d  = 32'hDEAD_BEEF;
        tick();
        check("reg_reload", 64'(bus.reg_q), 64'hDEAD_BEEF);
        @(negedge clk);
        bus.reg_en = 1'b0;
        reset      = 1'b1;
        #2;
        check("reg_reset_not_async", 64'(bus.reg_q), 64'hDEAD_BEEF);
        tick();
        check("reg_reset_mid_op", 64'(bus.reg_q), 64'h0);

        // Mux while reset is still high and between clock edges.
        @(negedge clk);
        bus.mux_d0 = 32'hAAAA_5555;
        bus.mux_d1 = 32'h1234_5678;
        bus.mux_s  = 1'b0;
        #1;
        check("mux_s0", 64'(bus.mux_y), 64'hAAAA_5555);
        bus.mux_s = 1'b1;
        #1;
        check("mux_s1", 64'(bus.mux_y), 64'h1234_5678);
        bus.mux_d1 = 32'h0F0F_0F0F;
        #1;
        check("mux_follow_d1", 64'(bus.mux_y), 64'h0F0F_0F0F);
        reset = 1'b0;

        // ALU vector table, applied between edges.
        for (int i = 0; i < 14; i++) begin
            bus.alu_ctrl = vecs[i].ctrl;
            bus.alu_a    = vecs[i].a;
            bus.alu_b    = vecs[i].b;
            #2;
            check($sformatf("alu_res[%0d]", i),  64'(bus.alu_result), 64'(vecs[i].res));
            check($sformatf("alu_cout[%0d]", i), 64'(bus.alu_cout),   64'(vecs[i].cout));
            check($sformatf("alu_zero[%0d]", i), 64'(bus.alu_zero),   64'(vecs[i].zero));
`ifdef ALU_OVERFLOW_EN
            check($sformatf("alu_ovf[%0d]", i),  64'(bus.alu_ovf),    64'(vecs[i].ovf));
`endif
        end

        // ALU stays valid across a reset edge.
        bus.alu_ctrl = 3'b010;
        bus.alu_a    = 32'h0000_0010;
        bus.alu_b    = 32'h0000_0020;
        reset        = 1'b1;
        tick();
        check("alu_during_reset", 64'(bus.alu_result), 64'h30);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
